// File: rtl/cipher_pkg.sv
// Shared constants and types for the per-character cipher datapath.
// The ciphertext stream buffer uses the FSM state type and the FIFO entry struct.
package cipher_pkg;

  localparam logic [7:0] NULL_CHAR    = 8'h00;
  localparam logic [1:0] MODE_ENCRYPT = 2'b10;
  localparam logic [7:0] LOWERCASE_A  = 8'h61;
  localparam logic [7:0] LOWERCASE_Z  = 8'h7A;
  localparam int         P_MOD        = 227;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } ctxt_buf_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] chr;
  } ctxt_entry_t;

endpackage

// File: rtl/ctxt_fifo_mem.sv
// Tagged first-word-fall-through storage for the ciphertext stream buffer.
// Occupancy is tracked by an AW+1-bit count so full/empty never rely on pointer compare.
module ctxt_fifo_mem
  import cipher_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_req,
  input  ctxt_entry_t push_data,
  input  logic        pop,
  output logic        push_ok,
  output ctxt_entry_t head,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  ctxt_entry_t       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push_req && (!full || pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ctxt_stream_buffer.sv
// Frames registered ciphertext chars into messages and streams them out as bytes.
// Tracks per-message length, dropped chars and invalid-plaintext cycles.
module ctxt_stream_buffer
  import cipher_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_err,
  input  logic             eom,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy,
  output logic             overflow,
  output logic [LEN_W-1:0] msg_len,
  output logic [LEN_W-1:0] err_count
);

  ctxt_buf_state_t  state_q, state_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic [LEN_W-1:0] err_count_q, err_count_d;
  logic             overflow_q, overflow_d;
  logic             eom_pend_q, eom_pend_d;

  logic        push_req, push_ok, pop, fifo_empty, fifo_full;
  ctxt_entry_t push_data, head;
  logic        eom_eff;

  // eom is a strobe; a blocked end-of-message is remembered until it lands.
  assign eom_eff = eom || eom_pend_q;
  assign pop     = !fifo_empty && out_ready;

  ctxt_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_req  (push_req),
    .push_data (push_data),
    .pop       (pop),
    .push_ok   (push_ok),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (eom && push_ok) ? FLUSH : COLLECT;
      COLLECT: if (eom_eff && push_ok) state_d = FLUSH;
      FLUSH:   if (pop && head.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    case (state_q)
      IDLE: begin
        push_req  = in_valid;
        push_data = '{last: eom, chr: in_char};
      end
      COLLECT: begin
        if (in_valid) begin
          push_req  = 1'b1;
          push_data = '{last: eom_eff, chr: in_char};
        end else if (eom_eff) begin
          push_req  = 1'b1;
          push_data = '{last: 1'b1, chr: NULL_CHAR};
        end
      end
      default: begin
        push_req  = 1'b0;
        push_data = '0;
      end
    endcase
  end

  always_comb begin
    msg_len_d   = msg_len_q;
    err_count_d = err_count_q;
    overflow_d  = overflow_q;
    eom_pend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          msg_len_d   = push_ok ? LEN_W'(1) : '0;
          overflow_d  = !push_ok;
          err_count_d = '0;
          eom_pend_d  = eom && !push_ok;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (!push_ok)               overflow_d = 1'b1;
          else if (msg_len_q != '1)   msg_len_d  = msg_len_q + 1'b1;
        end
        if (in_err && err_count_q != '1) err_count_d = err_count_q + 1'b1;
        eom_pend_d = eom_eff && !push_ok;
      end
      FLUSH: begin
        if (in_valid) overflow_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len_q   <= '0;
      err_count_q <= '0;
      overflow_q  <= 1'b0;
      eom_pend_q  <= 1'b0;
    end else begin
      msg_len_q   <= msg_len_d;
      err_count_q <= err_count_d;
      overflow_q  <= overflow_d;
      eom_pend_q  <= eom_pend_d;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign out_valid = !fifo_empty;
  assign out_char  = fifo_empty ? NULL_CHAR : head.chr;
  assign out_last  = !fifo_empty && head.last;
  assign busy      = (state_q != IDLE);
  assign overflow  = overflow_q;
  assign msg_len   = msg_len_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ctxt_stream_buffer.sv
// Directed bench for ctxt_stream_buffer: expected stream entries are queued as
// stimulus is driven and compared against each popped head.
module tb_ctxt_stream_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_err, eom, out_ready;
  logic [7:0] in_char;
  logic       out_valid, out_last, busy, overflow;
  logic [7:0] out_char, msg_len, err_count;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] sb[$];
  logic       last_pop_busy = 1'b0;

  always #5 clk = ~clk;

  ctxt_stream_buffer #(.DEPTH(16), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
    .in_err(in_err), .eom(eom), .out_ready(out_ready), .out_valid(out_valid),
    .out_char(out_char), .out_last(out_last), .busy(busy), .overflow(overflow),
    .msg_len(msg_len), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_char"},  32'(out_char),  0);
    chk({tag, "_out_last"},  32'(out_last),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_overflow"},  32'(overflow),  0);
    chk({tag, "_msg_len"},   32'(msg_len),   0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  // One clock: compare any pop at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_pop", 32'(out_valid), 0);
      else                chk("pop", {out_last, out_char}, 32'(sb.pop_front()));
      last_pop_busy = busy;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1; in_valid = 1'b0; eom = 1'b0;
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    chk({tag, "_left_in_sb"}, sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_char = 0; in_err = 0; eom = 0; out_ready = 0;
    #12;
    chk_reset("por");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of FLUSH with five stored entries
    foreach (sb[i]) ;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_char = 8'(8'h11 * (i + 1)); tick(); end
    in_valid = 1'b0; eom = 1'b1; tick(); eom = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_msg_len", 32'(msg_len), 4);
    #2 rst_n = 1'b0; #1;
    chk_reset("t1_async");
    tick();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_out_valid_after", 32'(out_valid), 0);

    // Three chars, then eom alone appends a NULL terminator
    out_ready = 1'b1;
    in_valid = 1'b1; in_char = 8'h3A; sb.push_back({1'b0, 8'h3A}); tick();
    chk("t2_out_valid_latency", 32'(out_valid), 1);
    in_char = 8'h05; sb.push_back({1'b0, 8'h05}); tick();
    in_char = 8'hE2; sb.push_back({1'b0, 8'hE2}); tick();
    in_valid = 1'b0; eom = 1'b1; sb.push_back({1'b1, 8'h00}); tick(); eom = 1'b0;
    chk("t2_busy_flush", 32'(busy), 1);
    drain("t2");
    chk("t2_last_pop_busy", 32'(last_pop_busy), 1);
    chk("t2_busy_after", 32'(busy), 0);
    chk("t2_msg_len", 32'(msg_len), 3);
    chk("t2_overflow", 32'(overflow), 0);

    // eom together with a real char; errors counted only while collecting
    out_ready = 1'b0;
    in_valid = 1'b1; in_char = 8'h41; sb.push_back({1'b0, 8'h41}); tick();
    chk("t6_err_cleared", 32'(err_count), 0);
    in_valid = 1'b0; in_err = 1'b1;
    tick(); tick(); tick();
    chk("t6_err3", 32'(err_count), 3);
    in_valid = 1'b1; in_char = 8'h7F; eom = 1'b1; sb.push_back({1'b1, 8'h7F}); tick();
    in_valid = 1'b0; eom = 1'b0;
    tick(); tick();
    chk("t6_err_flush_hold", 32'(err_count), 4);
    in_err = 1'b0;
    drain("t6");
    chk("t6_no_terminator", 32'(out_valid), 0);
    chk("t6_busy_after", 32'(busy), 0);
    chk("t6_msg_len", 32'(msg_len), 2);

    // 18 pushes into 16 entries with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_char = 8'(8'h80 + i);
      if (i < 16) sb.push_back({1'b0, 8'(8'h80 + i)});
      tick();
      if (i == 0) chk("t3_overflow_clear", 32'(overflow), 0);
    end
    in_valid = 1'b0;
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_msg_len", 32'(msg_len), 16);

    // Full FIFO: push and pop in the same cycle, then a blocked terminator
    in_valid = 1'b1; in_char = 8'hC5; out_ready = 1'b1; sb.push_back({1'b0, 8'hC5}); tick();
    chk("t4_msg_len", 32'(msg_len), 17);
    in_valid = 1'b0; out_ready = 1'b0; eom = 1'b1; sb.push_back({1'b1, 8'h00}); tick();
    eom = 1'b0; tick();
    chk("t4_busy_blocked", 32'(busy), 1);
    drain("t4");
    chk("t4_last_pop_busy", 32'(last_pop_busy), 1);
    chk("t4_busy_after", 32'(busy), 0);
    chk("t4_msg_len_after", 32'(msg_len), 17);

    // err_count saturation, then FLUSH ignores errors and drops chars
    out_ready = 1'b1;
    in_valid = 1'b1; in_char = 8'h55; sb.push_back({1'b0, 8'h55}); tick();
    chk("t5_overflow_clear", 32'(overflow), 0);
    in_valid = 1'b0; in_err = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_err10", 32'(err_count), 10);
    for (int i = 0; i < 290; i++) tick();
    chk("t5_err_sat", 32'(err_count), 255);
    out_ready = 1'b0; eom = 1'b1; sb.push_back({1'b1, 8'h00}); tick(); eom = 1'b0;
    in_valid = 1'b1; in_char = 8'h99;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0; in_err = 1'b0;
    chk("t5_err_flush", 32'(err_count), 255);
    chk("t5_overflow_flush", 32'(overflow), 1);
    chk("t5_msg_len", 32'(msg_len), 1);
    drain("t5");
    chk("t5_busy_after", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
